cable_packet_gen: RTL and testbench

- Generates deterministic AXI-Stream test packets for one Ethernet port of the cable tester. Two instances sit on the output side of the cable-test control block, one per port.
- Each instance consumes one pg_control bus plus the shared CYCLES_PER_PACKET and PACKET_COUNT values.
- Each instance returns a pg_status bus {halted, sent, busy} and drives the MAC TX stream.

---
 rtl/cable_packet_gen.sv | 153 +++++++++++++++
 tb/tb_cable_packet_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cable_packet_gen.sv
// cable_packet_gen: deterministic AXI-Stream test packet generator for one cable-tester port.
// Define PG_IPG_EN to insert IPG_CYCLES idle cycles between packets.
module cable_packet_gen #(
  parameter int DATA_WBITS = 512,
  parameter int IPG_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2:0]            pg_control,
  input  logic [7:0]            CYCLES_PER_PACKET,
  input  logic [63:0]           PACKET_COUNT,
  output logic [2:0]            pg_status,
  output logic [DATA_WBITS-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TVALID,
  output logic                  AXIS_TX_TLAST,
  input  logic                  AXIS_TX_TREADY
);
  localparam int LANES = DATA_WBITS / 32;

  if (DATA_WBITS % 32 != 0 || IPG_CYCLES < 1) begin : g_bad_param
    $error("cable_packet_gen: DATA_WBITS must be a multiple of 32 and IPG_CYCLES >= 1");
  end

`ifdef PG_IPG_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  logic [15:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t state_q, state_d;
  logic [63:0] pkt_total_q, pkt_total_d, packet_num_q, packet_num_d;
  logic [7:0]  cpp_q, cpp_d, cycle_idx_q, cycle_idx_d;
  logic        halt_pend_q, halt_pend_d, inj_pend_q, inj_pend_d;
  logic        corrupt_q, corrupt_d, halted_q, halted_d, sent_q, sent_d;
  logic        busy, hs, last, halt_eff, inj_eff;
  logic [DATA_WBITS-1:0] beat;

  assign busy     = state_q != IDLE;
  assign hs       = AXIS_TX_TVALID && AXIS_TX_TREADY;
  assign last     = cycle_idx_q == cpp_q - 8'd1;
  assign halt_eff = halt_pend_q || (pg_control[1] && busy);
  assign inj_eff  = inj_pend_q || (pg_control[2] && busy);

  always_comb begin
    state_d      = state_q;
    pkt_total_d  = pkt_total_q;
    packet_num_d = packet_num_q;
    cpp_d        = cpp_q;
    cycle_idx_d  = cycle_idx_q;
    halt_pend_d  = halt_eff;
    inj_pend_d   = inj_eff;
    corrupt_d    = corrupt_q;
    halted_d     = halted_q;
    sent_d       = hs && last;
`ifdef PG_IPG_EN
    gap_d        = gap_q;
`endif
    case (state_q)
      IDLE: if (pg_control[0]) begin
        pkt_total_d  = PACKET_COUNT;
        cpp_d        = CYCLES_PER_PACKET == 8'd0 ? 8'd1 : CYCLES_PER_PACKET;
        packet_num_d = '0;
        cycle_idx_d  = '0;
        halted_d     = 1'b0;
        corrupt_d    = 1'b0;
        state_d      = PACKET_COUNT != 64'd0 ? SEND : IDLE;
      end
      SEND: if (hs) begin
        cycle_idx_d = last ? 8'd0 : cycle_idx_q + 8'd1;
        if (last) packet_num_d = packet_num_q + 64'd1;
        if (last && (packet_num_q + 64'd1 == pkt_total_q || halt_eff)) begin
          state_d     = IDLE;
          halted_d    = halt_eff;
          halt_pend_d = 1'b0;
          inj_pend_d  = 1'b0;
        end
`ifdef PG_IPG_EN
        else if (last) begin
          state_d = GAP;
          gap_d   = '0;
        end
`endif
        else begin
          // corruption is fixed when a beat is loaded so a stalled beat never changes
          corrupt_d  = inj_eff;
          inj_pend_d = 1'b0;
        end
      end
`ifdef PG_IPG_EN
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == 16'(IPG_CYCLES - 1)) begin
          if (halt_eff) begin
            state_d     = IDLE;
            halted_d    = 1'b1;
            halt_pend_d = 1'b0;
            inj_pend_d  = 1'b0;
          end else begin
            state_d    = SEND;
            corrupt_d  = inj_eff;
            inj_pend_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pkt_total_q  <= '0;
      packet_num_q <= '0;
      cpp_q        <= '0;
      cycle_idx_q  <= '0;
      halt_pend_q  <= 1'b0;
      inj_pend_q   <= 1'b0;
      corrupt_q    <= 1'b0;
      halted_q     <= 1'b0;
      sent_q       <= 1'b0;
`ifdef PG_IPG_EN
      gap_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pkt_total_q  <= pkt_total_d;
      packet_num_q <= packet_num_d;
      cpp_q        <= cpp_d;
      cycle_idx_q  <= cycle_idx_d;
      halt_pend_q  <= halt_pend_d;
      inj_pend_q   <= inj_pend_d;
      corrupt_q    <= corrupt_d;
      halted_q     <= halted_d;
      sent_q       <= sent_d;
`ifdef PG_IPG_EN
      gap_q        <= gap_d;
`endif
    end
  end

  always_comb begin
    beat = '0;
    for (int i = 0; i < LANES; i++) beat[i*32 +: 32] = {packet_num_q[15:0], cycle_idx_q, 8'(i)};
    beat[0] = beat[0] ^ corrupt_q;
  end

  assign AXIS_TX_TVALID = state_q == SEND;
  assign AXIS_TX_TLAST  = AXIS_TX_TVALID && last;
  assign AXIS_TX_TDATA  = AXIS_TX_TVALID ? beat : '0;
  assign pg_status      = {halted_q, sent_q, busy};
endmodule

// File: tb/tb_cable_packet_gen.sv
// tb_cable_packet_gen: randomized self-checking bench for cable_packet_gen against a packet-list model.
module tb_cable_packet_gen;
  localparam int W = 512;
  localparam int L = W / 32;

  logic         clk = 0, resetn = 0, tready = 0;
  logic [2:0]   pg_control = '0, pg_status;
  logic [7:0]   cpp_in = '0;
  logic [63:0]  cnt_in = '0;
  logic [W-1:0] tdata;
  logic         tvalid, tlast;

  int n_cmp = 0, n_err = 0;
  logic [W-1:0] got_data[$];
  bit           got_last[$];
  bit           mark[0:4095];

  cable_packet_gen #(.DATA_WBITS(W), .IPG_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .pg_control(pg_control),
    .CYCLES_PER_PACKET(cpp_in), .PACKET_COUNT(cnt_in), .pg_status(pg_status),
    .AXIS_TX_TDATA(tdata), .AXIS_TX_TVALID(tvalid), .AXIS_TX_TLAST(tlast),
    .AXIS_TX_TREADY(tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pattern(input int p, input int c, input bit bad);
    logic [W-1:0] d;
    for (int i = 0; i < L; i++) d[i*32 +: 32] = {16'(p), 8'(c), 8'(i)};
    d[0] = d[0] ^ bad;
    return d;
  endfunction

  // mode: 0 ready high, 1 toggling, 2 random, 3 low for the first two valid cycles
  task automatic run(input string tag, input int count, input int cpp, input int mode,
                     input int halt_at, input int inj_at, input bit rnd_inj, input bit halt_start);
    int c = (cpp == 0) ? 1 : cpp;
    int beats = 0, sent = 0, send_cyc = 0, last_hs = -1, fall = -1, lim = count;
    bit halt_sent = 0, stall = 0, prev_last = 0, saw_busy = 0;
    logic [W-1:0] prev_data = '0;
    int p_exp;
    got_data.delete();
    got_last.delete();
    for (int i = 0; i < 4096; i++) mark[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      pg_control = '0;
      cnt_in = 64'(count);
      cpp_in = 8'(cpp);
      if (cyc == 0) pg_control = halt_start ? 3'b011 : 3'b001;
      tready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) :
               mode == 2 ? 1'($urandom_range(0, 1)) : (send_cyc >= 2);
      if (tvalid) begin
        if (beats == halt_at && !halt_sent) begin
          pg_control[1] = 1'b1;
          halt_sent = 1;
          lim = (beats / c + 1 < count) ? beats / c + 1 : count;
        end
        if (beats == inj_at || (rnd_inj && $urandom_range(0, 7) == 0)) begin
          pg_control[2] = 1'b1;
          if (beats + 1 < 4096) mark[beats+1] = 1;
        end
      end
      @(negedge clk);
      if (pg_status[1]) sent++;
      if (pg_status[0]) saw_busy = 1;
      if (stall && tvalid) begin
        check({tag, "_stall_data"}, tdata, prev_data);
        check({tag, "_stall_last"}, W'(tlast), W'(prev_last));
      end
      stall = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
      if (tvalid) send_cyc++;
      if (tvalid && tready) begin
        got_data.push_back(tdata);
        got_last.push_back(tlast);
        beats++;
        last_hs = cyc;
      end
      if (cyc > 0 && !pg_status[0] && !tvalid) begin
        fall = cyc;
        break;
      end
    end
    pg_control = '0;
    check({tag, "_finished"}, W'(fall != -1), W'(1));
    p_exp = lim;
    check({tag, "_nbeats"}, W'(got_data.size()), W'(p_exp * c));
    for (int b = 0; b < got_data.size() && b < p_exp * c; b++) begin
      check($sformatf("%s_data%0d", tag, b), got_data[b], pattern(b / c, b % c, mark[b]));
      check($sformatf("%s_last%0d", tag, b), W'(got_last[b]), W'(b % c == c - 1));
    end
    check({tag, "_sent"}, W'(sent), W'(p_exp));
    check({tag, "_halted"}, W'(pg_status[2]), W'(halt_sent));
    if (count > 0) check({tag, "_busy_fall"}, W'(fall), W'(last_hs + 1));
    else check({tag, "_never_busy"}, W'(saw_busy), W'(0));
  endtask

  initial begin
    int ones;
    #12;
    check("rst_tvalid", W'(tvalid), W'(0));
    check("rst_tlast", W'(tlast), W'(0));
    check("rst_tdata", tdata, '0);
    check("rst_status", W'(pg_status), W'(0));
    @(negedge clk); resetn = 1;

    @(posedge clk); #1; pg_control = 3'b110;
    @(posedge clk); #1; pg_control = '0;
    @(negedge clk);
    check("idle_halt_inject", W'(pg_status), W'(0));

    run("basic", 3, 4, 0, -1, -1, 0, 0);
    check("beat6_lane2", W'(got_data.size() > 5 ? got_data[5][95:64] : 32'hx), W'(32'h0001_0102));
    run("toggle", 3, 4, 1, -1, -1, 0, 0);
    run("halt", 100, 8, 0, 10, -1, 0, 0);
    run("inject", 2, 4, 3, -1, 0, 0, 0);
    ones = 0;
    foreach (got_data[b]) if (got_data[b][31:0] == 32'h0000_0101) ones++;
    check("inject_once", W'(ones), W'(1));
    run("cpp0", 2, 0, 0, -1, -1, 0, 0);
    run("count0", 0, 4, 0, -1, -1, 0, 0);
    run("start_halt", 2, 3, 0, -1, -1, 0, 1);

    @(posedge clk); #1; cnt_in = 64'd5; cpp_in = 8'd4; tready = 1; pg_control = 3'b001;
    @(posedge clk); #1; pg_control = '0;
    repeat (6) @(posedge clk);
    #3 resetn = 0;
    #1;
    check("mid_rst_tvalid", W'(tvalid), W'(0));
    check("mid_rst_tlast", W'(tlast), W'(0));
    check("mid_rst_tdata", tdata, '0);
    check("mid_rst_status", W'(pg_status), W'(0));
    @(negedge clk); resetn = 1;
    run("after_rst", 2, 2, 0, -1, -1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 5);
      int cp = $urandom_range(0, 6);
      int c1 = (cp == 0) ? 1 : cp;
      int h = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, (n - 1) * c1 - 1) : -1;
      run($sformatf("rnd%0d", r), n, cp, 2, h, -1, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
